// File: rtl/rs422_link_sched.sv
// RS422 link job scheduler: runs self-check and queued HDLC command jobs one
// at a time, with a per-job watchdog and a quiet gap between jobs.
module rs422_link_sched #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter int unsigned GAP_CYCLES     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         selfcheck_req,
    input  logic                         hdlc_req,
    input  logic [31:0]                  hdlc_cmd,
    input  logic                         selfcheck_finish,
    input  logic                         hdlc_tx_finish,
    input  logic                         hdlc_rx_finish,
    input  logic                         err_clr,
    output logic                         selfcheck_en,
    output logic                         hdlc_tx_en,
    output logic                         hdlc_rx_en,
    output logic [31:0]                  cmd_data,
    output logic                         busy,
    output logic [$clog2(CMD_DEPTH):0]   queue_level,
    output logic                         queue_full,
    output logic                         overflow_err,
    output logic                         timeout_err,
    output logic [15:0]                  jobs_done
);

    localparam int unsigned AW = $clog2(CMD_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StScRun, StLoad, StHdlcRun, StGap} state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem_q [CMD_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          sc_pending_q;
    logic          tx_done_q, rx_done_q;
    logic [31:0]   cmd_data_q;
    logic [WW-1:0] wd_q;
    logic [GW-1:0] gap_q;
    logic          overflow_q, timeout_q;
    logic [15:0]   jobs_q;

    logic pop, push, drop, enter_sc, job_done, job_timeout, expire, running;

    // FIFO handshake: a push is accepted into a full queue only when LOAD pops.
    always_comb begin
        pop  = (state_q == StLoad);
        push = hdlc_req && ((level_q != LW'(CMD_DEPTH)) || pop);
        drop = hdlc_req && !push;
    end

    // Next-state decode; completion takes priority over watchdog expiry.
    always_comb begin
        state_d     = state_q;
        enter_sc    = 1'b0;
        job_done    = 1'b0;
        job_timeout = 1'b0;
        expire      = (wd_q == WW'(TIMEOUT_CYCLES - 1));
        running     = (state_q == StScRun) || (state_q == StHdlcRun);
        unique case (state_q)
            StIdle: begin
                if (sc_pending_q) begin
                    state_d  = StScRun;
                    enter_sc = 1'b1;
                end else if (level_q != '0) begin
                    state_d = StLoad;
                end
            end
            StScRun: begin
                if (selfcheck_finish) begin
                    job_done = 1'b1;
                    state_d  = StGap;
                end else if (expire) begin
                    job_timeout = 1'b1;
                    state_d     = StGap;
                end
            end
            StLoad: state_d = StHdlcRun;
            StHdlcRun: begin
                if ((tx_done_q || hdlc_tx_finish) && (rx_done_q || hdlc_rx_finish)) begin
                    job_done = 1'b1;
                    state_d  = StGap;
                end else if (expire) begin
                    job_timeout = 1'b1;
                    state_d     = StGap;
                end
            end
            StGap: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode straight from the state register and done flags.
    always_comb begin
        selfcheck_en = (state_q == StScRun);
        hdlc_tx_en   = (state_q == StHdlcRun) && !tx_done_q;
        hdlc_rx_en   = (state_q == StHdlcRun) && !rx_done_q;
        busy         = (state_q != StIdle);
        cmd_data     = cmd_data_q;
        queue_level  = level_q;
        queue_full   = (level_q == LW'(CMD_DEPTH));
        overflow_err = overflow_q;
        timeout_err  = timeout_q;
        jobs_done    = jobs_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Command FIFO storage, pointers and occupancy; LOAD moves the head to cmd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cmd_data_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= hdlc_cmd;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                cmd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    // Pending self-check: a request in the entry cycle still re-arms it.
    always_ff @(posedge clk) begin
        if (rst) sc_pending_q <= 1'b0;
        else     sc_pending_q <= (sc_pending_q && !enter_sc) || selfcheck_req;
    end

    // Per-engine done flags, cleared by LOAD ahead of each HDLC job.
    always_ff @(posedge clk) begin
        if (rst || pop) begin
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
        end else if (state_q == StHdlcRun) begin
            tx_done_q <= tx_done_q || hdlc_tx_finish;
            rx_done_q <= rx_done_q || hdlc_rx_finish;
        end
    end

    // Watchdog restarts at 0 on every run-state entry; gap counter only runs in GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            gap_q <= '0;
        end else begin
            wd_q  <= (running && state_d == state_q) ? wd_q + WW'(1) : '0;
            gap_q <= (state_q == StGap) ? gap_q + GW'(1) : '0;
        end
    end

    // Sticky errors (set beats clear) and completed-job counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            jobs_q     <= '0;
        end else begin
            overflow_q <= drop || (overflow_q && !err_clr);
            timeout_q  <= job_timeout || (timeout_q && !err_clr);
            jobs_q     <= jobs_q + 16'(job_done);
        end
    end

endmodule
